// File: rtl/rst_seq_pkg.sv
// Shared types and elaboration-time parameter checks for the reset sequencer.
package rst_seq_pkg;

    typedef enum logic [2:0] {
        RESET     = 3'd0,
        COUNT     = 3'd1,
        RELEASE   = 3'd2,
        RUN       = 3'd3,
        SOFT_HOLD = 3'd4,
        SOFT_REL  = 3'd5,
        ACK       = 3'd6
    } state_e;

    function automatic int max_cnt(int rst_cycles, int stagger);
        return (rst_cycles > stagger) ? rst_cycles : stagger;
    endfunction

    // The hold/stagger counter only ever reaches max-1, but keep headroom for max itself.
    function automatic bit params_ok(int num_ch, int rst_cycles, int stagger,
                                     int sync_stages, int div_w, int cnt_w);
        return (num_ch >= 1) && (num_ch <= 16) &&
               (rst_cycles >= 1) && (stagger >= 1) &&
               (sync_stages >= 2) && (div_w >= 1) &&
               (cnt_w >= 1) && (cnt_w <= 30) &&
               (max_cnt(rst_cycles, stagger) < (1 << cnt_w));
    endfunction

endpackage

// File: rtl/ch_clk_div.sv
// Per-channel clock-enable divider: one enable every (ratio+1) cycles while the channel is out of reset.
module ch_clk_div
    import rst_seq_pkg::*;
#(
    parameter int DIV_W = 4
) (
    input  logic             clk_fr,
    input  logic             rst,
    input  logic             ch_rst_n,
    input  logic [DIV_W-1:0] div_ratio,
    output logic             ch_clk_en
);

    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] ratio_q;
    logic [DIV_W-1:0] ratio_eff;

    // A new period starts at div_cnt==0, so that is where the live ratio is taken.
    assign ratio_eff = (div_cnt == '0) ? div_ratio : ratio_q;

    always_ff @(posedge clk_fr or negedge rst) begin
        if (!rst) begin
            div_cnt <= '0;
            ratio_q <= '0;
        end else begin
            if (div_cnt == '0) begin
                ratio_q <= div_ratio;
            end
            if (!ch_rst_n) begin
                div_cnt <= '0;
            end else if (div_cnt == ratio_eff) begin
                div_cnt <= '0;
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end
        end
    end

    assign ch_clk_en = ch_rst_n & (div_cnt == '0);

endmodule

// File: rtl/rst_seq_gen.sv
// Reset sequencer: synchronises rst, releases channel resets in staggered order,
// and services a four-phase soft reset of a masked channel subset.
module rst_seq_gen
    import rst_seq_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int RST_CYCLES  = 5,
    parameter int STAGGER     = 4,
    parameter int SYNC_STAGES = 2,
    parameter int DIV_W       = 4,
    parameter int CNT_W       = 8
) (
    input  logic                    clk_fr,
    input  logic                    rst,
    input  logic                    sw_rst_req,
    output logic                    sw_rst_ack,
    input  logic [NUM_CH-1:0]       ch_mask,
    input  logic [NUM_CH*DIV_W-1:0] div_ratio,
    output logic [NUM_CH-1:0]       ch_rst_n,
    output logic [NUM_CH-1:0]       ch_clk_en,
    output logic                    seq_done,
    output logic [2:0]              state
);

    if (!params_ok(NUM_CH, RST_CYCLES, STAGGER, SYNC_STAGES, DIV_W, CNT_W)) begin : g_param_check
        $fatal(1, "rst_seq_gen: parameter out of range");
    end

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rst_sync;

    always_ff @(posedge clk_fr or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign rst_sync = sync_q[SYNC_STAGES-1];

    state_e            state_q, state_nx;
    logic [CNT_W-1:0]  cnt_q, cnt_nx;
    logic [NUM_CH-1:0] pend_q, pend_nx;
    logic [NUM_CH-1:0] ch_rst_q, ch_rst_nx;
    logic              done_q, done_nx;
    logic              ack_q, ack_nx;
    logic [NUM_CH-1:0] low_bit, rel_rst, rel_pend;

    // pend_q holds channels still waiting for release; the lowest set bit goes next.
    assign low_bit  = pend_q & (~pend_q + NUM_CH'(1));
    assign rel_rst  = ch_rst_q | low_bit;
    assign rel_pend = pend_q & ~low_bit;

    always_ff @(posedge clk_fr or negedge rst) begin
        if (!rst) begin
            state_q  <= RESET;
            cnt_q    <= '0;
            pend_q   <= '0;
            ch_rst_q <= '0;
            done_q   <= 1'b0;
            ack_q    <= 1'b0;
        end else begin
            state_q  <= state_nx;
            cnt_q    <= cnt_nx;
            pend_q   <= pend_nx;
            ch_rst_q <= ch_rst_nx;
            done_q   <= done_nx;
            ack_q    <= ack_nx;
        end
    end

    always_comb begin
        state_nx  = state_q;
        cnt_nx    = cnt_q;
        pend_nx   = pend_q;
        ch_rst_nx = ch_rst_q;
        done_nx   = done_q;
        ack_nx    = ack_q;
        case (state_q)
            RESET: begin
                if (rst_sync) begin
                    state_nx = COUNT;
                    cnt_nx   = '0;
                    pend_nx  = '1;
                end
            end
            COUNT: begin
                if (cnt_q == CNT_W'(RST_CYCLES - 1)) begin
                    cnt_nx    = '0;
                    ch_rst_nx = rel_rst;
                    pend_nx   = rel_pend;
                    if (rel_pend == '0) begin
                        state_nx = RUN;
                        done_nx  = 1'b1;
                    end else begin
                        state_nx = RELEASE;
                    end
                end else begin
                    cnt_nx = cnt_q + CNT_W'(1);
                end
            end
            RELEASE: begin
                if (cnt_q == CNT_W'(STAGGER - 1)) begin
                    cnt_nx    = '0;
                    ch_rst_nx = rel_rst;
                    pend_nx   = rel_pend;
                    if (rel_pend == '0) begin
                        state_nx = RUN;
                        done_nx  = 1'b1;
                    end
                end else begin
                    cnt_nx = cnt_q + CNT_W'(1);
                end
            end
            RUN: begin
                if (sw_rst_req && !ack_q) begin
                    state_nx  = SOFT_HOLD;
                    cnt_nx    = '0;
                    pend_nx   = ch_mask;
                    ch_rst_nx = ch_rst_q & ~ch_mask;
                    done_nx   = 1'b0;
                end
            end
            SOFT_HOLD: begin
                // The first masked channel comes out on the same edge the hold ends.
                if (cnt_q == CNT_W'(RST_CYCLES - 1)) begin
                    cnt_nx = '0;
                    if (pend_q == '0) begin
                        state_nx = SOFT_REL;
                    end else begin
                        ch_rst_nx = rel_rst;
                        pend_nx   = rel_pend;
                        if (rel_pend == '0) begin
                            state_nx = ACK;
                            ack_nx   = 1'b1;
                        end else begin
                            state_nx = SOFT_REL;
                        end
                    end
                end else begin
                    cnt_nx = cnt_q + CNT_W'(1);
                end
            end
            SOFT_REL: begin
                if (pend_q == '0) begin
                    state_nx = ACK;
                    ack_nx   = 1'b1;
                end else if (cnt_q == CNT_W'(STAGGER - 1)) begin
                    cnt_nx    = '0;
                    ch_rst_nx = rel_rst;
                    pend_nx   = rel_pend;
                    if (rel_pend == '0) begin
                        state_nx = ACK;
                        ack_nx   = 1'b1;
                    end
                end else begin
                    cnt_nx = cnt_q + CNT_W'(1);
                end
            end
            ACK: begin
                if (!sw_rst_req) begin
                    state_nx = RUN;
                    ack_nx   = 1'b0;
                    done_nx  = 1'b1;
                end
            end
            default: begin
                state_nx = RESET;
            end
        endcase
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        ch_clk_div #(
            .DIV_W(DIV_W)
        ) u_div (
            .clk_fr    (clk_fr),
            .rst       (rst),
            .ch_rst_n  (ch_rst_q[k]),
            .div_ratio (div_ratio[k*DIV_W +: DIV_W]),
            .ch_clk_en (ch_clk_en[k])
        );
    end

    assign ch_rst_n   = ch_rst_q;
    assign sw_rst_ack = ack_q;
    assign seq_done   = done_q;
    assign state      = state_q;

endmodule

// File: tb/tb_rst_seq_gen.sv
// Self-checking bench for rst_seq_gen: randomized directed steps against an event-time reference model.
module tb_rst_seq_gen;

    localparam int NUM_CH      = 4;
    localparam int RST_CYCLES  = 5;
    localparam int STAGGER     = 4;
    localparam int SYNC_STAGES = 2;
    localparam int DIV_W       = 4;
    localparam int CNT_W       = 8;
    localparam int BASE        = SYNC_STAGES + 1 + RST_CYCLES;

    logic                    clk_fr;
    logic                    rst;
    logic                    sw_rst_req;
    logic                    sw_rst_ack;
    logic [NUM_CH-1:0]       ch_mask;
    logic [NUM_CH*DIV_W-1:0] div_ratio;
    logic [NUM_CH-1:0]       ch_rst_n;
    logic [NUM_CH-1:0]       ch_clk_en;
    logic                    seq_done;
    logic [2:0]              state;

    int compared;
    int fails;

    rst_seq_gen #(
        .NUM_CH      (NUM_CH),
        .RST_CYCLES  (RST_CYCLES),
        .STAGGER     (STAGGER),
        .SYNC_STAGES (SYNC_STAGES),
        .DIV_W       (DIV_W),
        .CNT_W       (CNT_W)
    ) dut (
        .clk_fr     (clk_fr),
        .rst        (rst),
        .sw_rst_req (sw_rst_req),
        .sw_rst_ack (sw_rst_ack),
        .ch_mask    (ch_mask),
        .div_ratio  (div_ratio),
        .ch_rst_n   (ch_rst_n),
        .ch_clk_en  (ch_clk_en),
        .seq_done   (seq_done),
        .state      (state)
    );

    initial clk_fr = 1'b0;
    always #5 clk_fr = ~clk_fr;

    // Reference model: tracks when each channel is due out of reset and when its next enable falls.
    typedef enum {M_PWR, M_RUN, M_SOFT, M_ACK} mmode_e;
    mmode_e            m_mode;
    int                m_t;
    int                rel_at  [NUM_CH];
    int                en_next [NUM_CH];
    int                ack_at;
    int                done_at;
    logic [NUM_CH-1:0] exp_rst;
    logic [NUM_CH-1:0] exp_en;
    logic              exp_done;
    logic              exp_ack;

    task automatic modelReset();
        m_t      = 0;
        m_mode   = M_PWR;
        exp_rst  = '0;
        exp_en   = '0;
        exp_done = 1'b0;
        exp_ack  = 1'b0;
        ack_at   = -1;
        for (int k = 0; k < NUM_CH; k++) begin
            rel_at[k]  = BASE + k * STAGGER;
            en_next[k] = -1;
        end
        done_at = BASE + (NUM_CH - 1) * STAGGER;
    endtask

    task automatic modelStep();
        int j;
        m_t++;
        for (int k = 0; k < NUM_CH; k++) begin
            if (exp_rst[k] && exp_en[k]) en_next[k] = m_t + int'(div_ratio[k*DIV_W +: DIV_W]);
        end
        case (m_mode)
            M_PWR: begin
                if (m_t == done_at) begin
                    m_mode   = M_RUN;
                    exp_done = 1'b1;
                end
            end
            M_RUN: begin
                if (sw_rst_req) begin
                    j = 0;
                    exp_done = 1'b0;
                    for (int k = 0; k < NUM_CH; k++) begin
                        if (ch_mask[k]) begin
                            exp_rst[k] = 1'b0;
                            rel_at[k]  = m_t + RST_CYCLES + j * STAGGER;
                            j++;
                        end
                    end
                    ack_at = (j == 0) ? m_t + RST_CYCLES + 1 : m_t + RST_CYCLES + (j - 1) * STAGGER;
                    m_mode = M_SOFT;
                end
            end
            M_SOFT: begin
                if (m_t == ack_at) begin
                    exp_ack = 1'b1;
                    m_mode  = M_ACK;
                end
            end
            M_ACK: begin
                if (!sw_rst_req) begin
                    exp_ack  = 1'b0;
                    exp_done = 1'b1;
                    m_mode   = M_RUN;
                end
            end
            default: ;
        endcase
        for (int k = 0; k < NUM_CH; k++) begin
            if (rel_at[k] == m_t) begin
                exp_rst[k] = 1'b1;
                en_next[k] = m_t;
            end
            exp_en[k] = exp_rst[k] && (en_next[k] == m_t);
        end
    endtask

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s t=%0d: observed %0h expected %0h", tag, m_t, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        cmp({tag, ".ch_rst_n"},   32'(ch_rst_n),   32'(exp_rst));
        cmp({tag, ".ch_clk_en"},  32'(ch_clk_en),  32'(exp_en));
        cmp({tag, ".seq_done"},   32'(seq_done),   32'(exp_done));
        cmp({tag, ".sw_rst_ack"}, 32'(sw_rst_ack), 32'(exp_ack));
        if (exp_done) cmp({tag, ".state_run"}, 32'(state), 32'd3);
    endtask

    task automatic checkReset(input string tag);
        cmp({tag, ".ch_rst_n"},   32'(ch_rst_n),   32'd0);
        cmp({tag, ".ch_clk_en"},  32'(ch_clk_en),  32'd0);
        cmp({tag, ".seq_done"},   32'(seq_done),   32'd0);
        cmp({tag, ".sw_rst_ack"}, 32'(sw_rst_ack), 32'd0);
        cmp({tag, ".state"},      32'(state),      32'd0);
    endtask

    task automatic applyStimulus(input logic req, input logic [NUM_CH-1:0] mask,
                                 input logic [NUM_CH*DIV_W-1:0] ratio);
        sw_rst_req = req;
        ch_mask    = mask;
        div_ratio  = ratio;
    endtask

    task automatic runCycles(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_fr);
            #1;
            modelStep();
            checkOutput(tag);
        end
    endtask

    function automatic logic [NUM_CH*DIV_W-1:0] randRatio();
        logic [NUM_CH*DIV_W-1:0] r;
        r = '0;
        for (int k = 0; k < NUM_CH; k++) r[k*DIV_W +: DIV_W] = DIV_W'($urandom_range(0, 3));
        return r;
    endfunction

    logic [NUM_CH*DIV_W-1:0] ratio;

    initial begin
        compared = 0;
        fails    = 0;
        modelReset();

        // Power-on with ch1 dividing by three
        rst   = 1'b0;
        ratio = randRatio();
        ratio[1*DIV_W +: DIV_W] = DIV_W'(2);
        applyStimulus(1'b0, '0, ratio);
        #3 checkReset("por_async");
        repeat (2) @(posedge clk_fr);
        #1 checkReset("por_held");
        @(negedge clk_fr);
        rst = 1'b1;
        modelReset();
        runCycles(26, "poweron");

        // ch1 ratio to 0 mid-period, others rerolled
        ratio = randRatio();
        ratio[1*DIV_W +: DIV_W] = '0;
        applyStimulus(1'b0, '0, ratio);
        runCycles(10, "ratio_change");

        // Soft reset of channels 0 and 2
        applyStimulus(1'b1, 4'b0101, ratio);
        runCycles(RST_CYCLES + STAGGER + 3, "soft_0101");
        applyStimulus(1'b0, 4'(($urandom)), ratio);
        runCycles(4, "soft_0101_drop");

        // Soft reset with empty mask
        applyStimulus(1'b1, '0, ratio);
        runCycles(RST_CYCLES + 4, "soft_empty");
        applyStimulus(1'b0, '0, ratio);
        runCycles(4, "soft_empty_drop");

        // Random masks; mask/ratio wiggled after acceptance must be ignored
        for (int i = 0; i < 4; i++) begin
            ratio = randRatio();
            applyStimulus(1'b1, 4'($urandom), ratio);
            runCycles(3, "soft_rand_a");
            applyStimulus(1'b1, 4'($urandom), ratio);
            runCycles(RST_CYCLES + NUM_CH * STAGGER, "soft_rand_b");
            applyStimulus(1'b0, 4'($urandom), randRatio());
            runCycles(3, "soft_rand_drop");
        end

        // Async reset pulse while releasing soft-reset channels
        applyStimulus(1'b1, 4'b1111, ratio);
        runCycles(RST_CYCLES + 3, "soft_all");
        #2 rst = 1'b0;
        #1 checkReset("async_mid");
        applyStimulus(1'b0, '0, ratio);
        repeat (2) @(posedge clk_fr);
        #1 checkReset("async_held");
        #3 rst = 1'b1;
        modelReset();
        runCycles(26, "repower");

        // Request held high through power-on
        #2 rst = 1'b0;
        applyStimulus(1'b1, 4'($urandom), randRatio());
        #1 checkReset("req_por_async");
        @(negedge clk_fr);
        rst = 1'b1;
        modelReset();
        runCycles(BASE + (NUM_CH - 1) * STAGGER + 3, "req_early");
        runCycles(20, "req_early_soft");
        applyStimulus(1'b0, '0, ratio);
        runCycles(3, "req_early_drop");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/rst_seq_gen.md
Name: rst_seq_gen

Overview:
- Parametrised, synthesizable reset sequencer and clock-enable generator for multi-domain DUT benches and SoC glue.
- Synchronises the asynchronous active-low reset `rst` to `clk_fr` and releases NUM_CH per-channel resets in staggered order after a programmable hold.
- Generates a per-channel divided clock enable, gated by that channel's reset.
- Adds a four-phase software soft-reset of a masked subset of channels while the others keep running.

Parameters:
- NUM_CH, 4: number of reset/enable channels (1..16).
- RST_CYCLES, 5: hold cycles after synchronised reset release and during soft reset (>=1).
- STAGGER, 4: cycles between consecutive channel releases (>=1).
- SYNC_STAGES, 2: reset synchroniser depth (>=2).
- DIV_W, 4: width of each per-channel divide ratio.
- CNT_W, 8: hold/stagger counter width; must hold max(RST_CYCLES, STAGGER).

Ports:
- clk_fr  in  1  free-running clock.
- rst  in  1  reset, asynchronous, active-low.
- sw_rst_req  in  1  soft-reset request, four-phase level.
- sw_rst_ack  out  1  soft-reset acknowledge.
- ch_mask  in  NUM_CH  channels hit by soft reset; sampled on request acceptance.
- div_ratio  in  NUM_CH*DIV_W  per-channel divide: enable every div_ratio+1 cycles.
- ch_rst_n  out  NUM_CH  per-channel active-low reset, registered.
- ch_clk_en  out  NUM_CH  per-channel clock enable.
- seq_done  out  1  high in RUN only.
- state  out  3  FSM state for debug.

Behaviour:
- Reset domain: one clock `clk_fr`; reset `rst` is asynchronous and active-low. Assertion is asynchronous. Deassertion passes through a SYNC_STAGES flop chain, so `rst_sync` goes high on the SYNC_STAGES-th `clk_fr` edge after `rst` rises.
- Reset values: ch_rst_n=0, ch_clk_en=0, sw_rst_ack=0, seq_done=0, state=RESET, all counters 0.
- `rst` falling in any state returns everything to reset values immediately, with no clock needed.
- FSM states and encoding: RESET=0, COUNT=1, RELEASE=2, RUN=3, SOFT_HOLD=4, SOFT_REL=5, ACK=6.
- RESET -> COUNT on the first edge with rst_sync=1.
- COUNT:
  - Counter runs 0..RST_CYCLES-1, then -> RELEASE.
  - ch_rst_n[0] rises on the RELEASE entry edge.
  - Each ch_rst_n[k] rises STAGGER edges after ch_rst_n[k-1].
- RELEASE -> RUN on the same edge the last channel is released; seq_done rises on that edge.
- RUN -> SOFT_HOLD when sw_rst_req=1 and sw_rst_ack=0.
  - ch_mask is captured on this edge.
  - Masked ch_rst_n fall on this edge.
  - seq_done falls on this edge.
- SOFT_HOLD: hold RST_CYCLES cycles, then -> SOFT_REL.
- SOFT_REL:
  - Release masked channels in ascending index order, STAGGER edges apart.
  - Skip unmasked channels; unmasked channels are never disturbed.
  - After the last masked release -> ACK, with sw_rst_ack=1.
- Empty captured mask: SOFT_HOLD still runs its RST_CYCLES hold, then SOFT_REL -> ACK on the next edge.
- ACK:
  - Hold sw_rst_ack=1 until sw_rst_req=0.
  - Then sw_rst_ack=0 and -> RUN, with seq_done=1.
- sw_rst_req seen outside RUN is not accepted; it is serviced on RUN entry if still high.
- ch_mask and div_ratio changes outside their sample points have no effect.
- Clock-enable divider, per channel:
  - div_cnt[k] is cleared while ch_rst_n[k]=0.
  - Otherwise it increments and wraps to 0 after reaching the latched ratio.
  - ch_clk_en[k] = ch_rst_n[k] & (div_cnt[k]==0), so the first enable occurs in the first cycle the channel is out of reset.
  - The ratio is latched from div_ratio at each wrap (div_cnt==0), so mid-period changes take effect at the next period.
  - Ratio 0 gives a constant-1 enable.
- Simultaneous events: a request on the RELEASE->RUN edge is accepted one edge later. A channel entering soft reset drops ch_clk_en on the same edge as ch_rst_n.

Decomposition:
- Package rst_seq_pkg holds:
  - the state_e enum with the encodings above;
  - a function max_cnt(RST_CYCLES, STAGGER) for CNT_W checking;
  - an elaboration-time assertion helper for the parameter ranges.
- Sub-module ch_clk_div (one instance per channel, generate loop) holds the divider counter, ratio latch and enable logic.
- The synchroniser and FSM stay in the top level.

Test Plan:
- Power-on, defaults, rst rises before edge 1 -> ch_rst_n[0] high at edge 8, ch_rst_n[1..3] at 12/16/20, seq_done at 20.
- div_ratio ch1=2 after release -> ch_clk_en[1] pattern 1,0,0 repeating; change to 0 mid-period -> constant 1 from the next wrap.
- Soft reset, ch_mask=4'b0101 in RUN -> ch 0 and 2 low for 5 cycles; ch0 released, ch2 released 4 edges later; ch 1 and 3 enables uninterrupted; sw_rst_ack rises with the ch2 release and falls one edge after sw_rst_req drops.
- ch_mask=0 soft reset -> no channel toggles; sw_rst_ack asserts after the 5-cycle hold.
- rst pulsed low mid-SOFT_REL, not clock-aligned -> all outputs 0 immediately; the full power-on sequence repeats with the same timing as the first scenario.
- sw_rst_req held high from power-on -> ignored until RUN, accepted on the edge after seq_done rises.
